// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
//  Definitions shared by the frequency-meter block: FSM state encodings
//  (2 bits) and the helper that sizes the gate-window counter.
//  No ports.
// -----------------------------------------------------------------------------
package freq_meter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // The gate counter runs GATE_CYCLES-1 down to 0, so clog2(GATE_CYCLES)
    // bits are enough; never return less than one bit.
    function automatic int gate_cnt_w(input int gate_cycles);
        int w;
        w = $clog2(gate_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//  Brings an asynchronous level into the clk_100MHz domain through a chain of
//  SYNC_STAGES flops and produces a one-cycle pulse on each rising edge of the
//  synchronised level. Reusable for general input conditioning.
//
//  Ports
//   clk_100MHz  in   reference clock, posedge
//   rst         in   synchronous, active-high reset
//   sig_in      in   asynchronous input level
//   rise        out  one-cycle pulse per rising edge of the synchronised level
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_dly_q;

    // Shift chain: stage 0 samples the raw input, each later stage samples
    // its predecessor.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sync_d[gi] = sig_in;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~s_dly_q;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//  Counts rising edges of a divided clock (sampled as data) over a gate window
//  of GATE_CYCLES reference cycles and publishes the count with a one-cycle
//  valid strobe. Counter saturates at 2^CNT_W-1 and flags overflow.
//
//  Build option: define FREQ_METER_CONT_EN for continuous mode, where holding
//  start high at the end of a window immediately opens the next window
//  (back-to-back, no dead cycle). Undefined: one-shot windows only.
//
//  Ports
//   clk_100MHz   in   reference clock, posedge
//   rst          in   synchronous, active-high reset (aborts a window)
//   sig_in       in   signal under measurement, asynchronous
//   start        in   level, sampled in IDLE to begin a measurement
//   busy         out  high while measuring or publishing
//   count_out    out  edge count of last completed window (held)
//   count_valid  out  one-cycle strobe when count_out/overflow update
//   overflow     out  last window saturated (held with count_out)
// -----------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
);

    localparam int               GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             edge_pulse;

    logic [1:0]       state_q,       state_d;
    logic [GW-1:0]    gate_q,        gate_d;
    logic [CNT_W-1:0] edge_cnt_q,    edge_cnt_d;
    logic             ovf_q,         ovf_d;
    logic [CNT_W-1:0] count_out_q,   count_out_d;
    logic             overflow_q,    overflow_d;
    logic             count_valid_q, count_valid_d;

    // Edge counter value after this cycle's edge (saturating) and the
    // matching overflow flag.
    logic             edge_sat;
    logic [CNT_W-1:0] cnt_step;
    logic             ovf_step;

`ifdef FREQ_METER_CONT_EN
    // Result of a window that ended while the next one started in the same
    // cycle; published one cycle later so latency matches one-shot mode.
    logic             res_pend_q, res_pend_d;
    logic [CNT_W-1:0] res_cnt_q,  res_cnt_d;
    logic             res_ovf_q,  res_ovf_d;
`endif

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .sig_in     (sig_in),
        .rise       (edge_pulse)
    );

    assign edge_sat = edge_pulse && (edge_cnt_q == CNT_MAX);
    assign cnt_step = (edge_pulse && !edge_sat) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign ovf_step = ovf_q | edge_sat;

    always_comb begin
        state_d       = state_q;
        gate_d        = gate_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_d         = ovf_q;
        count_out_d   = count_out_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;
`ifdef FREQ_METER_CONT_EN
        res_pend_d    = 1'b0;
        res_cnt_d     = res_cnt_q;
        res_ovf_d     = res_ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_MEASURE;
                    gate_d     = GATE_LOAD;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end

            ST_MEASURE: begin
                // An edge on the final gate cycle still belongs to this window.
                edge_cnt_d = cnt_step;
                ovf_d      = ovf_step;
                if (gate_q == '0) begin
`ifdef FREQ_METER_CONT_EN
                    if (start) begin
                        // Close this window and open the next one in the same
                        // cycle; the next window starts from zero.
                        res_pend_d = 1'b1;
                        res_cnt_d  = cnt_step;
                        res_ovf_d  = ovf_step;
                        gate_d     = GATE_LOAD;
                        edge_cnt_d = '0;
                        ovf_d      = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    gate_d = gate_q - GW'(1);
                end
            end

            ST_DONE: begin
                count_out_d   = edge_cnt_q;
                overflow_d    = ovf_q;
                count_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef FREQ_METER_CONT_EN
        // Only set while the FSM stays in MEASURE, so never collides with DONE.
        if (res_pend_q) begin
            count_out_d   = res_cnt_q;
            overflow_d    = res_ovf_q;
            count_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            ovf_q         <= 1'b0;
            count_out_q   <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
`ifdef FREQ_METER_CONT_EN
            res_pend_q    <= 1'b0;
            res_cnt_q     <= '0;
            res_ovf_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gate_q        <= gate_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_q         <= ovf_d;
            count_out_q   <= count_out_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
`ifdef FREQ_METER_CONT_EN
            res_pend_q    <= res_pend_d;
            res_cnt_q     <= res_cnt_d;
            res_ovf_q     <= res_ovf_d;
`endif
        end
    end

    assign busy        = (state_q == ST_MEASURE) || (state_q == ST_DONE);
    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//  Two freq_meter instances (CNT_W=16 and CNT_W=8, GATE_CYCLES=1000) share the
//  clock, reset and measured signal. Expected results are queued when a window
//  is started and compared when count_valid appears.
// -----------------------------------------------------------------------------
module tb_freq_meter;

    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        start16 = 1'b0;
    logic        start8 = 1'b0;

    logic        busy16, cv16, ovf16;
    logic [15:0] cnt16;
    logic        busy8, cv8, ovf8;
    logic [7:0]  cnt8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;   // 0: held 0, 1: held 1, 2: 50 MHz, 3: 10 MHz
    int ph = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t m16, m8;
    int pushed16 = 0, pushed8 = 0, seen16 = 0, seen8 = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clk_100MHz  (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .start       (start16),
        .busy        (busy16),
        .count_out   (cnt16),
        .count_valid (cv16),
        .overflow    (ovf16)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk_100MHz  (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .start       (start8),
        .busy        (busy8),
        .count_out   (cnt8),
        .count_valid (cv8),
        .overflow    (ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divided-clock source, changing 2 ns after each reference edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: sig_in = 1'b0;
                1: sig_in = 1'b1;
                2: sig_in = ~sig_in;
                default: begin
                    sig_in = (ph < 5);
                    ph = (ph == 9) ? 0 : ph + 1;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: compare each published result against the queue.
    always @(negedge clk) begin
        if (cv16 === 1'b1) begin
            seen16++;
            $display("txn dut16 count=%0d overflow=%0d cycle=%0d", cnt16, ovf16, cyc);
            if (q16.size() == 0) begin
                chk("unexpected_valid16", 32'(cv16), 32'(0));
            end else begin
                m16 = q16.pop_front();
                chk("count16", 32'(cnt16), m16.cnt);
                chk("ovf16", 32'(ovf16), 32'(m16.ovf));
                chk("valid_cycle16", 32'(cyc), 32'(m16.cyc));
            end
        end
        if (cv8 === 1'b1) begin
            seen8++;
            $display("txn dut8 count=%0d overflow=%0d cycle=%0d", cnt8, ovf8, cyc);
            if (q8.size() == 0) begin
                chk("unexpected_valid8", 32'(cv8), 32'(0));
            end else begin
                m8 = q8.pop_front();
                chk("count8", 32'(cnt8), m8.cnt);
                chk("ovf8", 32'(ovf8), 32'(m8.ovf));
                chk("valid_cycle8", 32'(cyc), 32'(m8.cyc));
            end
        end
    end

    // One-shot window: pulse start, measure busy length, confirm the result
    // arrived. With pulses set, extra start pulses are driven while busy.
    task automatic run(input bit use8, input int exp_cnt, input bit exp_ovf, input bit pulses);
        exp_t e;
        int n;
        e.cnt = 32'(exp_cnt);
        e.ovf = exp_ovf;
        e.cyc = cyc + 1 + G + 1;
        if (use8) begin
            q8.push_back(e);
            pushed8++;
            start8 = 1'b1;
        end else begin
            q16.push_back(e);
            pushed16++;
            start16 = 1'b1;
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        n = 0;
        while (((use8 ? busy8 : busy16) === 1'b1) && n < 2 * G) begin
            n++;
            start16 = (pulses && (n == 10 || n == 500)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start16 = 1'b0;
        chk(use8 ? "busy_len8" : "busy_len16", 32'(n), 32'(G + 1));
        repeat (3) @(negedge clk);
        chk(use8 ? "result_arrived8" : "result_arrived16",
            32'(use8 ? q8.size() : q16.size()), 32'(0));
    endtask

    initial begin
        // Reset held over two rising edges (20 ns).
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy16", 32'(busy16), 32'(0));
        chk("rst_valid16", 32'(cv16), 32'(0));
        chk("rst_count16", 32'(cnt16), 32'(0));
        chk("rst_ovf16", 32'(ovf16), 32'(0));
        chk("rst_busy8", 32'(busy8), 32'(0));
        chk("rst_valid8", 32'(cv8), 32'(0));
        chk("rst_count8", 32'(cnt8), 32'(0));
        chk("rst_ovf8", 32'(ovf8), 32'(0));

        // 10 MHz and 50 MHz on the 16-bit meter.
        mode = 3; repeat (20) @(negedge clk);
        run(1'b0, 100, 1'b0, 1'b0);
        mode = 2; repeat (20) @(negedge clk);
        run(1'b0, 500, 1'b0, 1'b0);

        // Static input, low then high: no edges.
        mode = 0; repeat (20) @(negedge clk);
        run(1'b0, 0, 1'b0, 1'b0);
        mode = 1; repeat (20) @(negedge clk);
        run(1'b0, 0, 1'b0, 1'b0);

        // 8-bit meter: saturation then a clean run clears overflow.
        mode = 2; repeat (20) @(negedge clk);
        run(1'b1, 255, 1'b1, 1'b0);
        mode = 3; repeat (20) @(negedge clk);
        run(1'b1, 100, 1'b0, 1'b0);

        // Start pulses while busy must not open another window.
        run(1'b0, 100, 1'b0, 1'b1);

        // Reset 400 cycles into a window: abort, outputs cleared, no strobe.
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (399) @(negedge clk);
        chk("abort_busy_before", 32'(busy16), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy16", 32'(busy16), 32'(0));
        chk("abort_valid16", 32'(cv16), 32'(0));
        chk("abort_count16", 32'(cnt16), 32'(0));
        chk("abort_ovf16", 32'(ovf16), 32'(0));
        chk("abort_count8", 32'(cnt8), 32'(0));
        rst = 1'b0;
        repeat (G + 20) @(negedge clk);
        chk("abort_idle16", 32'(busy16), 32'(0));

`ifdef FREQ_METER_CONT_EN
        // Continuous mode: start held for three back-to-back windows.
        begin
            int t0;
            exp_t e;
            t0 = cyc + 1;
            for (int k = 1; k <= 3; k++) begin
                e.cnt = 32'(100);
                e.ovf = 1'b0;
                e.cyc = t0 + k * G + 1;
                q16.push_back(e);
                pushed16++;
            end
            start16 = 1'b1;
            repeat (3 * G) @(negedge clk);
            start16 = 1'b0;
            repeat (10) @(negedge clk);
            chk("cont_results_arrived", 32'(q16.size()), 32'(0));
            chk("cont_idle_after", 32'(busy16), 32'(0));
        end
`endif

        chk("valid_total16", 32'(seen16), 32'(pushed16));
        chk("valid_total8", 32'(seen8), 32'(pushed8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
